// File: rtl/serial_adder_if.sv
// Request/result bundle for the bit-serial adder: operands and start in,
// busy/done status and the registered result out.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one combinational full adder plus a registered carry
// produce a WIDTH-bit sum over WIDTH shift cycles.

// Combinational 1-bit full adder.
module fac (
    input  logic x,
    input  logic y,
    input  logic carry_in,
    output logic z,
    output logic carry_out
);
    assign z         = x ^ y ^ carry_in;
    assign carry_out = (x & y) | (carry_in & (x ^ y));
endmodule

module serial_adder #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] racc;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             z;
    logic             carry_out;

    fac u_fac (
        .x        (ra[0]),
        .y        (rb[0]),
        .carry_in (carry),
        .z        (z),
        .carry_out(carry_out)
    );

    // Controller and datapath: load on accept, shift LSB-first, publish on the last shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ra       <= '0;
            rb       <= '0;
            racc     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.sum  <= '0;
            bus.cout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        ra       <= bus.a;
                        rb       <= bus.b;
                        racc     <= '0;
                        carry    <= bus.cin;
                        cnt      <= '0;
                        state    <= SHIFT;
                        bus.busy <= 1'b1;
                    end
                end
                SHIFT: begin
                    ra    <= {1'b0, ra[WIDTH-1:1]};
                    rb    <= {1'b0, rb[WIDTH-1:1]};
                    racc  <= {z, racc[WIDTH-1:1]};
                    carry <= carry_out;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                        bus.sum  <= {z, racc[WIDTH-1:1]};
                        bus.cout <= carry_out;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    // The DONE->IDLE edge also accepts a waiting request, giving one
                    // result per WIDTH+1 cycles; requests during SHIFT are ignored.
                    if (bus.start) begin
                        ra       <= bus.a;
                        rb       <= bus.b;
                        racc     <= '0;
                        carry    <= bus.cin;
                        cnt      <= '0;
                        state    <= SHIFT;
                        bus.busy <= 1'b1;
                    end else begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: 8-bit instance for latency, wrap, ignore,
// reset and back-to-back scenarios; 4-bit instance for the exhaustive sweep.
module tb_serial_adder;
    logic clk;
    logic rst;
    int   total;
    int   passed;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(4)) bus4 ();

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk),
        .rst(rst),
        .bus(bus8.slave)
    );

    serial_adder #(.WIDTH(4)) u4 (
        .clk(clk),
        .rst(rst),
        .bus(bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one 8-bit request; lat = edges from accept edge to done, -1 on timeout.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                       output logic [7:0] s, output logic co, output int lat);
        bus8.a     = av;
        bus8.b     = bv;
        bus8.cin   = cv;
        bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus8.done) begin
                lat = i;
                break;
            end
        end
        s  = bus8.sum;
        co = bus8.cout;
    endtask

    task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic cv,
                       output logic [3:0] s, output logic co, output int lat);
        bus4.a     = av;
        bus4.b     = bv;
        bus4.cin   = cv;
        bus4.start = 1'b1;
        @(posedge clk); #1;
        bus4.start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (bus4.done) begin
                lat = i;
                break;
            end
        end
        s  = bus4.sum;
        co = bus4.cout;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus8.busy, bus8.done, bus8.cout, bus8.sum} !== 11'd0)
            $display("FAIL reset_outputs: got busy=%b done=%b cout=%b sum=%h, want all 0",
                     bus8.busy, bus8.done, bus8.cout, bus8.sum);
        else passed++;
        total++;
        if ({bus4.busy, bus4.done, bus4.cout, bus4.sum} !== 7'd0)
            $display("FAIL reset_outputs4: got busy=%b done=%b cout=%b sum=%h, want all 0",
                     bus4.busy, bus4.done, bus4.cout, bus4.sum);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (bus8.busy !== 1'b0) $display("FAIL idle_no_start: busy=%b want 0", bus8.busy);
        else passed++;
    endtask

    task automatic test_basic();
        int busy_cycles;
        @(posedge clk); #1;
        bus8.a     = 8'h0F;
        bus8.b     = 8'h01;
        bus8.cin   = 1'b0;
        bus8.start = 1'b1;
        @(posedge clk); #1;   // E0
        bus8.start = 1'b0;
        busy_cycles = bus8.busy ? 1 : 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (bus8.busy) busy_cycles++;
            total++;
            if (bus8.done !== (k == 8))
                $display("FAIL basic_done_timing: edge E%0d done=%b want %b", k, bus8.done, k == 8);
            else passed++;
        end
        total++;
        if (bus8.sum !== 8'h10 || bus8.cout !== 1'b0)
            $display("FAIL basic_sum: got cout=%b sum=%h want cout=0 sum=10", bus8.cout, bus8.sum);
        else passed++;
        @(posedge clk); #1;   // E9
        total++;
        if (busy_cycles !== 9 || bus8.busy !== 1'b0 || bus8.done !== 1'b0)
            $display("FAIL basic_busy: busy cycles=%0d busy=%b done=%b want 9,0,0",
                     busy_cycles, bus8.busy, bus8.done);
        else passed++;
        total++;
        if (bus8.sum !== 8'h10) $display("FAIL basic_hold: sum=%h want 10", bus8.sum);
        else passed++;
    endtask

    task automatic test_wrap();
        logic [7:0] s;
        logic       co;
        int         lat;
        @(posedge clk); #1;
        op8(8'hFF, 8'h01, 1'b0, s, co, lat);
        total++;
        if (lat !== 8 || s !== 8'h00 || co !== 1'b1)
            $display("FAIL wrap_ff_01: lat=%0d cout=%b sum=%h want 8,1,00", lat, co, s);
        else passed++;
        @(posedge clk); #1;
        op8(8'hFF, 8'hFF, 1'b1, s, co, lat);
        total++;
        if (lat !== 8 || s !== 8'hFF || co !== 1'b1)
            $display("FAIL wrap_ff_ff_1: lat=%0d cout=%b sum=%h want 8,1,FF", lat, co, s);
        else passed++;
    endtask

    task automatic test_exhaustive4();
        logic [3:0] s;
        logic       co;
        int         lat;
        int         bad;
        int         wide;
        logic [4:0] exp;
        bad  = 0;
        wide = 0;
        @(posedge clk); #1;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    op4(4'(ai), 4'(bi), 1'(ci), s, co, lat);
                    exp = 5'(ai) + 5'(bi) + 5'(ci);
                    total++;
                    if (lat !== 4 || {co, s} !== exp) begin
                        bad++;
                        if (bad <= 5)
                            $display("FAIL exh4 a=%h b=%h cin=%0d: lat=%0d got %h want lat 4 %h",
                                     ai, bi, ci, lat, {co, s}, exp);
                    end else passed++;
                    @(posedge clk); #1;
                    total++;
                    if (bus4.done !== 1'b0) begin
                        wide++;
                        if (wide <= 5)
                            $display("FAIL exh4_done_width a=%h b=%h: done=%b want 0 next cycle",
                                     ai, bi, bus4.done);
                    end else passed++;
                end
            end
        end
    endtask

    task automatic test_ignore();
        int lat;
        @(posedge clk); #1;
        bus8.a     = 8'h12;
        bus8.b     = 8'h34;
        bus8.cin   = 1'b0;
        bus8.start = 1'b1;
        @(posedge clk); #1;   // E0
        bus8.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus8.a     = 8'hAA;
        bus8.b     = 8'h55;
        bus8.start = 1'b1;
        @(posedge clk); #1;   // E3
        bus8.start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus8.done) begin
                lat = 3 + i;
                break;
            end
        end
        total++;
        if (lat !== 8 || bus8.sum !== 8'h46 || bus8.cout !== 1'b0)
            $display("FAIL ignore_mid_shift: lat=%0d cout=%b sum=%h want 8,0,46",
                     lat, bus8.cout, bus8.sum);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (bus8.busy !== 1'b0) $display("FAIL ignore_no_reload: busy=%b want 0", bus8.busy);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] s;
        logic       co;
        int         lat;
        int         seen;
        @(posedge clk); #1;
        bus8.a     = 8'h12;
        bus8.b     = 8'h34;
        bus8.cin   = 1'b1;
        bus8.start = 1'b1;
        @(posedge clk); #1;   // E0
        bus8.start = 1'b0;
        repeat (3) @(posedge clk);   // E3
        #3;
        rst = 1'b1;
        #1;
        total++;
        if ({bus8.busy, bus8.done, bus8.cout, bus8.sum} !== 11'd0)
            $display("FAIL reset_mid_async: busy=%b done=%b cout=%b sum=%h want all 0",
                     bus8.busy, bus8.done, bus8.cout, bus8.sum);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus8.done || bus8.busy) seen++;
        end
        total++;
        if (seen !== 0) $display("FAIL reset_mid_no_done: active cycles=%0d want 0", seen);
        else passed++;
        op8(8'h5A, 8'h25, 1'b1, s, co, lat);
        total++;
        if (lat !== 8 || s !== 8'h80 || co !== 1'b0)
            $display("FAIL reset_mid_fresh: lat=%0d cout=%b sum=%h want 8,0,80", lat, co, s);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] oa  [4];
        logic [7:0] ob  [4];
        logic       oc  [4];
        logic [8:0] exp [3];
        int         early;
        oa[0] = 8'h01; ob[0] = 8'h02; oc[0] = 1'b0; exp[0] = 9'h003;
        oa[1] = 8'h80; ob[1] = 8'h80; oc[1] = 1'b1; exp[1] = 9'h101;
        oa[2] = 8'h3C; ob[2] = 8'hC3; oc[2] = 1'b0; exp[2] = 9'h0FF;
        oa[3] = 8'hEE; ob[3] = 8'hEE; oc[3] = 1'b1;
        @(posedge clk); #1;
        bus8.a     = oa[0];
        bus8.b     = ob[0];
        bus8.cin   = oc[0];
        bus8.start = 1'b1;
        @(posedge clk); #1;   // E0
        bus8.a   = oa[1];
        bus8.b   = ob[1];
        bus8.cin = oc[1];
        for (int k = 0; k < 3; k++) begin
            early = 0;
            for (int c = 1; c <= 7; c++) begin
                @(posedge clk); #1;
                if (bus8.done) early++;
            end
            @(posedge clk); #1;   // E(9k+8)
            total++;
            if (early !== 0 || bus8.done !== 1'b1 || {bus8.cout, bus8.sum} !== exp[k])
                $display("FAIL b2b_op%0d: early=%0d done=%b got %h want done 1 %h",
                         k, early, bus8.done, {bus8.cout, bus8.sum}, exp[k]);
            else passed++;
            if (k == 2) bus8.start = 1'b0;
            @(posedge clk); #1;   // E(9k+9)
            total++;
            if (bus8.done !== 1'b0 || bus8.busy !== (k < 2))
                $display("FAIL b2b_accept%0d: done=%b busy=%b want 0,%b",
                         k, bus8.done, bus8.busy, k < 2);
            else passed++;
            bus8.a   = oa[k + 1 < 3 ? k + 2 : 3];
            bus8.b   = ob[k + 1 < 3 ? k + 2 : 3];
            bus8.cin = oc[k + 1 < 3 ? k + 2 : 3];
        end
    endtask

    initial begin
        total       = 0;
        passed      = 0;
        rst         = 1'b1;
        bus8.start  = 1'b0;
        bus8.a      = '0;
        bus8.b      = '0;
        bus8.cin    = 1'b0;
        bus4.start  = 1'b0;
        bus4.a      = '0;
        bus4.b      = '0;
        bus4.cin    = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_exhaustive4();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
